// File: rtl/uart_program_loader_pkg.sv
// Shared constants for the UART program loader: defaults, loader FSM and receiver state encodings.
package uart_program_loader_pkg;

  localparam int         DEFAULT_CLKS_PER_BIT = 868;
  localparam logic [7:0] DEFAULT_SYNC_BYTE    = 8'hA5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_COUNT = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // A count byte of zero stands for a full 256-instruction image.
  function automatic logic [8:0] decode_count(input logic [7:0] count_byte);
    return (count_byte == 8'd0) ? 9'd256 : {1'b0, count_byte};
  endfunction

endpackage

// File: rtl/uart_program_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, glitch-filtered start bit, centre sampling,
// one-cycle byte_valid / byte_err pulses.
module uart_rx
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta, rx_sync, rx_prev;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  // Flops reset to the idle-high line level so releasing reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'd0;
      byte_data  <= 8'd0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            clk_cnt  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt  <= '0;
            bit_idx  <= 3'd0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift_reg;
            end else begin
              byte_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a framed program (sync, count, 3-byte words MSB-first) from UART into instruction
// memory while holding the CPU.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        load_req,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [23:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  logic [7:0] byte_data;
  logic       byte_valid, byte_err;
  logic [2:0] state;
  logic [1:0] byte_idx;
  logic [8:0] write_cnt, n_count;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  // load_req outranks everything, including a completing third byte, so a restart never writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      byte_idx  <= 2'd0;
      write_cnt <= 9'd0;
      n_count   <= 9'd0;
      wr_en     <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 24'd0;
    end else begin
      wr_en <= 1'b0;
      if (load_req) begin
        state     <= ST_SYNC;
        byte_idx  <= 2'd0;
        write_cnt <= 9'd0;
      end else begin
        case (state)
          ST_SYNC: begin
            if (byte_err) state <= ST_ERROR;
            else if (byte_valid && byte_data == SYNC_BYTE) state <= ST_COUNT;
          end
          ST_COUNT: begin
            if (byte_err) begin
              state <= ST_ERROR;
            end else if (byte_valid) begin
              n_count   <= decode_count(byte_data);
              byte_idx  <= 2'd0;
              write_cnt <= 9'd0;
              wr_addr   <= 8'd0;
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (byte_err) begin
              state <= ST_ERROR;
            end else if (byte_valid) begin
              case (byte_idx)
                2'd0:    wr_data[23:16] <= byte_data;
                2'd1:    wr_data[15:8]  <= byte_data;
                default: wr_data[7:0]   <= byte_data;
              endcase
              if (byte_idx == 2'd2) begin
                byte_idx <= 2'd0;
                wr_en    <= 1'b1;
                state    <= ST_WRITE;
              end else begin
                byte_idx <= byte_idx + 2'd1;
              end
            end
          end
          ST_WRITE: begin
            wr_addr   <= wr_addr + 8'd1;
            write_cnt <= write_cnt + 9'd1;
            state     <= (write_cnt + 9'd1 == n_count) ? ST_DONE : ST_DATA;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = (state == ST_SYNC) || (state == ST_COUNT) ||
                     (state == ST_DATA) || (state == ST_WRITE);
  assign cpu_hold  = busy || (state == ST_ERROR);
  assign done      = (state == ST_DONE);
  assign frame_err = (state == ST_ERROR);

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomised self-checking bench: serial frames are checked against a byte-stream model of
// the load protocol; a second, faster instance covers the 256-word wrap.
module tb_uart_program_loader;

  localparam int         CPB      = 16;
  localparam int         CPB_FAST = 8;
  localparam logic [7:0] SYNC     = 8'hA5;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [7:0]  addr;
    logic [23:0] data;
  } wr_rec_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        rx = 1'b1, load_req = 1'b0;
  logic        rx_fast = 1'b1, load_req_fast = 1'b0;
  logic        wr_en, cpu_hold, busy, done, frame_err;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_en_fast, cpu_hold_fast, busy_fast, done_fast, frame_err_fast;
  logic [7:0]  wr_addr_fast;
  logic [23:0] wr_data_fast;

  int assert_count = 0, fail_count = 0, wide_count = 0;
  wr_rec_t got_q[$], got_fast_q[$], exp_q[$];
  logic prev_wr_en = 1'b0, prev_wr_en_fast = 1'b0;
  bit found;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .rx(rx), .load_req(load_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .frame_err(frame_err)
  );

  uart_program_loader #(.CLKS_PER_BIT(CPB_FAST), .SYNC_BYTE(SYNC)) dut_fast (
    .clk(clk), .rst(rst), .rx(rx_fast), .load_req(load_req_fast),
    .wr_en(wr_en_fast), .wr_addr(wr_addr_fast), .wr_data(wr_data_fast),
    .cpu_hold(cpu_hold_fast), .busy(busy_fast), .done(done_fast), .frame_err(frame_err_fast)
  );

  always #5 clk = ~clk;

  // Record every write and flag any strobe wider than one cycle.
  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
    if (wr_en_fast) got_fast_q.push_back({wr_addr_fast, wr_data_fast});
    if ((wr_en && prev_wr_en) || (wr_en_fast && prev_wr_en_fast)) wide_count <= wide_count + 1;
    prev_wr_en      <= wr_en;
    prev_wr_en_fast <= wr_en_fast;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit fast);
    int cpb;
    logic [9:0] frame;
    cpb   = fast ? CPB_FAST : CPB;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (fast) rx_fast = frame[i]; else rx = frame[i];
      repeat (cpb) @(negedge clk);
    end
    if (fast) rx_fast = 1'b1; else rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_load(input bit fast);
    @(negedge clk);
    if (fast) load_req_fast = 1'b1; else load_req = 1'b1;
    @(negedge clk);
    load_req_fast = 1'b0;
    load_req      = 1'b0;
    checkOutput("hold_after_load", fast ? cpu_hold_fast : cpu_hold, 1);
    checkOutput("busy_after_load", fast ? busy_fast : busy, 1);
  endtask

  // Protocol model: skip to the first sync byte, read the count, emit whole 3-byte words only.
  task automatic model_load(input byte_q_t bytes, output bit exp_done);
    int i, n, cnt;
    i = 0; cnt = 0;
    exp_q.delete();
    exp_done = 1'b0;
    while (i < bytes.size() && bytes[i] != SYNC) i++;
    i++;
    if (i >= bytes.size()) return;
    n = (bytes[i] == 8'd0) ? 256 : int'(bytes[i]);
    i++;
    while (cnt < n && i + 2 < bytes.size()) begin
      exp_q.push_back({8'(cnt), bytes[i], bytes[i+1], bytes[i+2]});
      i += 3;
      cnt++;
    end
    exp_done = (cnt == n);
  endtask

  task automatic applyStimulus(input byte_q_t bytes, input string tag, input bit fast);
    wr_rec_t got[$];
    bit exp_done;
    if (fast) got_fast_q.delete(); else got_q.delete();
    pulse_load(fast);
    foreach (bytes[k]) send_byte(bytes[k], 1'b1, fast);
    repeat (3 * CPB) @(negedge clk);
    model_load(bytes, exp_done);
    if (fast) got = got_fast_q; else got = got_q;
    checkOutput({tag, "_count"}, got.size(), exp_q.size());
    foreach (exp_q[k]) begin
      if (k < got.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, k), got[k].addr, exp_q[k].addr);
        checkOutput($sformatf("%s_data%0d", tag, k), got[k].data, exp_q[k].data);
      end
    end
    checkOutput({tag, "_done"}, fast ? done_fast : done, exp_done);
    checkOutput({tag, "_hold"}, fast ? cpu_hold_fast : cpu_hold, !exp_done);
    checkOutput({tag, "_busy"}, fast ? busy_fast : busy, !exp_done);
    checkOutput({tag, "_wr_addr"}, fast ? wr_addr_fast : wr_addr, 8'(exp_q.size()));
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_wr_en"}, wr_en, 0);
    checkOutput({tag, "_wr_addr"}, wr_addr, 0);
    checkOutput({tag, "_wr_data"}, wr_data, 0);
    checkOutput({tag, "_cpu_hold"}, cpu_hold, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    byte_q_t q;
    logic [7:0] b;
    int n, drop;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    applyStimulus(q, "basic", 1'b0);
    q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h01};
    applyStimulus(q, "lead", 1'b0);

    // Random frames with leading noise; the last one is cut short to leave a partial word.
    for (int r = 0; r < 3; r++) begin
      q.delete();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        do b = 8'($urandom); while (b == SYNC);
        q.push_back(b);
      end
      q.push_back(SYNC);
      n = (r == 2) ? int'($urandom_range(2, 3)) : int'($urandom_range(1, 3));
      q.push_back(8'(n));
      drop = (r == 2) ? int'($urandom_range(1, 2)) : 0;
      for (int d = 0; d < 3 * n - drop; d++) q.push_back(8'($urandom));
      applyStimulus(q, $sformatf("rand%0d", r), 1'b0);
    end

    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    q = '{8'hA5, 8'h01, 8'($urandom), 8'($urandom), 8'($urandom)};
    applyStimulus(q, "glitch", 1'b0);

    got_q.delete();
    pulse_load(1'b0);
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    repeat (CPB) @(negedge clk);
    checkOutput("err_frame_err", frame_err, 1);
    checkOutput("err_cpu_hold", cpu_hold, 1);
    checkOutput("err_busy", busy, 0);
    checkOutput("err_done", done, 0);
    send_byte(8'h33, 1'b1, 1'b0);
    send_byte(8'h44, 1'b1, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    checkOutput("err_no_write", got_q.size(), 0);
    checkOutput("err_sticky", frame_err, 1);
    q = '{8'hA5, 8'h01, 8'h9A, 8'hBC, 8'hDE};
    applyStimulus(q, "recover", 1'b0);

    pulse_load(1'b0);
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values("mid_reset");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    q = '{8'hA5, 8'h01, 8'h65, 8'h43, 8'h21};
    applyStimulus(q, "after_reset", 1'b0);

    // Restart arriving in the same cycle as the completing byte must suppress the write.
    got_q.delete();
    pulse_load(1'b0);
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'hBB, 1'b1, 1'b0);
    found = 1'b0;
    fork
      send_byte(8'hCC, 1'b1, 1'b0);
      begin
        for (int c = 0; c < 12 * CPB && !found; c++) begin
          @(negedge clk);
          if (dut.u_rx.byte_valid) begin
            load_req = 1'b1;
            @(negedge clk);
            load_req = 1'b0;
            found = 1'b1;
          end
        end
      end
    join
    checkOutput("coincide_seen", found, 1);
    repeat (CPB) @(negedge clk);
    checkOutput("coincide_no_write", got_q.size(), 0);
    checkOutput("coincide_busy", busy, 1);
    checkOutput("coincide_hold", cpu_hold, 1);
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h0F, 1'b1, 1'b0);
    send_byte(8'h1E, 1'b1, 1'b0);
    send_byte(8'h2D, 1'b1, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    checkOutput("coincide_resync_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      checkOutput("coincide_resync_addr", got_q[0].addr, 0);
      checkOutput("coincide_resync_data", got_q[0].data, 24'h0F1E2D);
    end
    checkOutput("coincide_resync_done", done, 1);

    q = '{8'hA5, 8'h00};
    for (int d = 0; d < 768; d++) q.push_back(8'($urandom));
    applyStimulus(q, "wrap", 1'b1);

    checkOutput("wr_en_single_cycle", wide_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
